ddfs_phase_dither: RTL and testbench

//  Phase accumulator and dither-injection stage of the DDFS.
//  - Accumulates a frequency tuning word (FTW) every enabled cycle.
//  - Adds LFSR-derived dither below the truncation point, then truncates to a PHASE_BITS address for the sine ROM stage.
//  - Consumes the LFSR output word and drives its step enable, so the LFSR advances once per phase sample.
//  - FTW updates are double-buffered and applied at accumulator wrap, which keeps the output phase-continuous.

---
 rtl/ddfs_pkg.sv | 20 ++
 rtl/ddfs_ftw_shadow.sv | 79 +++++++
 rtl/ddfs_phase_dither.sv | 102 ++++++++++
 tb/tb_ddfs_phase_dither.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddfs_pkg.sv
// Shared defaults, FTW state encoding and dither alignment helper for the DDFS.
package ddfs_pkg;

   localparam int ACC_BITS_DEF    = 32;
   localparam int PHASE_BITS_DEF  = 12;
   localparam int DITHER_BITS_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PENDING = 2'd2
   } ftw_state_t;

   // Left shift that places the dither LSBs directly below the truncation point.
   function automatic int dither_shift(input int acc_bits, input int phase_bits,
                                       input int dither_bits);
      return acc_bits - phase_bits - dither_bits;
   endfunction

endpackage

// File: rtl/ddfs_ftw_shadow.sv
// Double-buffered tuning word: direct writes while stopped, shadowed writes
// while running, applied on accumulator wrap or when the accumulator stops.
module ddfs_ftw_shadow
   import ddfs_pkg::*;
#(
   parameter int ACC_BITS = ACC_BITS_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                ftw_dv,
   input  logic [ACC_BITS-1:0] ftw,
   input  logic                carry_next,
   output logic [ACC_BITS-1:0] ftw_active,
   output logic                ftw_busy
);

   ftw_state_t          state, state_nxt;
   logic [ACC_BITS-1:0] ftw_shadow, shadow_nxt, active_nxt;
   logic                busy_nxt;

   // State and tuning-word registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ftw_active <= '0;
         ftw_shadow <= '0;
         ftw_busy   <= 1'b0;
      end else begin
         state      <= state_nxt;
         ftw_active <= active_nxt;
         ftw_shadow <= shadow_nxt;
         ftw_busy   <= busy_nxt;
      end
   end

   // Next-state logic; a write landing on the applying edge keeps the word pending.
   always_comb begin
      state_nxt  = state;
      active_nxt = ftw_active;
      shadow_nxt = ftw_shadow;
      busy_nxt   = ftw_busy;
      case (state)
         IDLE: begin
            if (ftw_dv) active_nxt = ftw;
            if (enable) state_nxt = RUN;
         end
         RUN: begin
            if (!enable) begin
               // Accumulator is not stepping this edge, so a direct write is safe.
               if (ftw_dv) active_nxt = ftw;
               state_nxt = IDLE;
            end else if (ftw_dv) begin
               shadow_nxt = ftw;
               busy_nxt   = 1'b1;
               state_nxt  = PENDING;
            end
         end
         PENDING: begin
            if (!enable) begin
               active_nxt = ftw_dv ? ftw : ftw_shadow;
               busy_nxt   = 1'b0;
               state_nxt  = IDLE;
            end else if (ftw_dv) begin
               shadow_nxt = ftw;
            end else if (carry_next) begin
               active_nxt = ftw_shadow;
               busy_nxt   = 1'b0;
               state_nxt  = RUN;
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ddfs_phase_dither.sv
// DDFS phase accumulator with LFSR dither injected below the truncation point.
module ddfs_phase_dither
   import ddfs_pkg::*;
#(
   parameter int ACC_BITS    = ACC_BITS_DEF,
   parameter int PHASE_BITS  = PHASE_BITS_DEF,
   parameter int DITHER_BITS = DITHER_BITS_DEF,
   parameter int LFSR_BITS   = 32
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic                  i_Enable,
   input  logic                  i_Phase_Clr,
   input  logic                  i_FTW_DV,
   input  logic [ACC_BITS-1:0]   i_FTW,
   input  logic                  i_Dither_En,
   input  logic [LFSR_BITS-1:0]  i_LFSR_Data,
   output logic                  o_LFSR_Enable,
   output logic                  o_FTW_Busy,
   output logic [PHASE_BITS-1:0] o_Phase,
   output logic                  o_Phase_DV,
   output logic                  o_Wrap
);

   localparam int DSHIFT = dither_shift(ACC_BITS, PHASE_BITS, DITHER_BITS);

   logic [ACC_BITS-1:0]   ftw_active;
   logic [ACC_BITS:0]     acc_sum;
   logic                  carry_next;
   logic [ACC_BITS-1:0]   acc_p0;
   logic                  carry_p0, vld_p0;
   logic [PHASE_BITS-1:0] phase_p1;
   logic                  wrap_p1, vld_p1;
   logic                  unused_lfsr;

   // Dither is scaled so its LSB sits DSHIFT bits up; it never reaches the carry.
   function automatic logic [ACC_BITS-1:0] dither_add(input logic [ACC_BITS-1:0]    acc,
                                                     input logic [DITHER_BITS-1:0] d,
                                                     input logic                   en);
      logic [ACC_BITS-1:0] d_ext;
      d_ext = en ? ({{(ACC_BITS-DITHER_BITS){1'b0}}, d} << DSHIFT) : '0;
      return acc + d_ext;
   endfunction

   function automatic logic [PHASE_BITS-1:0] truncate(input logic [ACC_BITS-1:0] sum);
      return sum[ACC_BITS-1 -: PHASE_BITS];
   endfunction

   assign o_LFSR_Enable = i_Enable;
   assign acc_sum       = {1'b0, acc_p0} + {1'b0, ftw_active};
   assign carry_next    = i_Enable & ~i_Phase_Clr & acc_sum[ACC_BITS];
   assign unused_lfsr   = ^i_LFSR_Data[LFSR_BITS-1:DITHER_BITS];

   ddfs_ftw_shadow #(.ACC_BITS(ACC_BITS)) u_ftw (
      .clk        (i_Clk),
      .rst        (i_Rst),
      .enable     (i_Enable),
      .ftw_dv     (i_FTW_DV),
      .ftw        (i_FTW),
      .carry_next (carry_next),
      .ftw_active (ftw_active),
      .ftw_busy   (o_FTW_Busy)
   );

   // Stage p0: phase accumulator and carry; clear overrides accumulation.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         acc_p0   <= '0;
         carry_p0 <= 1'b0;
         vld_p0   <= 1'b0;
      end else begin
         vld_p0 <= i_Enable;
         if (i_Phase_Clr) begin
            acc_p0   <= '0;
            carry_p0 <= 1'b0;
         end else if (i_Enable) begin
            {carry_p0, acc_p0} <= acc_sum;
         end else begin
            carry_p0 <= 1'b0;
         end
      end
   end

   // Stage p1: dither injection and truncation; phase holds while not valid.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         phase_p1 <= '0;
         wrap_p1  <= 1'b0;
         vld_p1   <= 1'b0;
      end else begin
         vld_p1  <= vld_p0;
         wrap_p1 <= carry_p0;
         if (vld_p0)
            phase_p1 <= truncate(dither_add(acc_p0, i_LFSR_Data[DITHER_BITS-1:0], i_Dither_En));
      end
   end

   assign o_Phase    = phase_p1;
   assign o_Phase_DV = vld_p1;
   assign o_Wrap     = wrap_p1;

endmodule

// File: tb/tb_ddfs_phase_dither.sv
// Bench for ddfs_phase_dither: scoreboard queue of expected phase samples,
// table-driven dither vectors and hand-written FTW update sequences.
module tb_ddfs_phase_dither;

   logic        clk, rst, enable, phase_clr, ftw_dv, dither_en;
   logic [31:0] ftw, lfsr;
   logic        lfsr_enable, ftw_busy, phase_dv, wrap;
   logic [11:0] phase;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0] phase;
      logic        wrap;
   } exp_t;
   exp_t q[$];
   exp_t mon_e;

   typedef struct {
      logic        den;
      logic [31:0] lfsr;
      logic [31:0] ftw;
      logic [11:0] phase;
   } vec_t;
   vec_t vecs[6];

   ddfs_phase_dither dut (
      .i_Clk         (clk),
      .i_Rst         (rst),
      .i_Enable      (enable),
      .i_Phase_Clr   (phase_clr),
      .i_FTW_DV      (ftw_dv),
      .i_FTW         (ftw),
      .i_Dither_En   (dither_en),
      .i_LFSR_Data   (lfsr),
      .o_LFSR_Enable (lfsr_enable),
      .o_FTW_Busy    (ftw_busy),
      .o_Phase       (phase),
      .o_Phase_DV    (phase_dv),
      .o_Wrap        (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every valid sample is compared against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && phase_dv) begin
         if (q.size() == 0) begin
            chk("unexpected_dv", 32'(phase_dv), 32'd0);
         end else begin
            mon_e = q.pop_front();
            chk("phase", 32'(phase), 32'(mon_e.phase));
            chk("wrap", 32'(wrap), 32'(mon_e.wrap));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [11:0] p, input logic w);
      exp_t e;
      e.phase = p;
      e.wrap  = w;
      q.push_back(e);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      q.delete();
      enable = 0; phase_clr = 0; ftw_dv = 0; dither_en = 0; lfsr = 0; ftw = 0;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic write_idle(input logic [31:0] v);
      ftw_dv = 1'b1;
      ftw    = v;
      step();
      ftw_dv = 1'b0;
      chk("idle_write_busy", 32'(ftw_busy), 32'd0);
   endtask

   task automatic drain(input string name);
      enable = 1'b0;
      ftw_dv = 1'b0;
      phase_clr = 1'b0;
      step(); step(); step();
      chk(name, q.size(), 32'd0);
   endtask

   // Run FTW 0x1000_0000 and post writes while running; the first wrap is on sample 16.
   task automatic run_pending(input string name, input logic [31:0] w1, input int n1,
                              input logic [31:0] w2, input int n2, input int nsamp);
      logic [32:0] macc;
      logic [31:0] cur;
      apply_reset();
      write_idle(32'h1000_0000);
      enable = 1'b1;
      macc = '0;
      cur  = 32'h1000_0000;
      for (int n = 1; n <= nsamp; n++) begin
         ftw_dv = 1'b0;
         if (n == n1) begin ftw_dv = 1'b1; ftw = w1; end
         if (n == n2) begin ftw_dv = 1'b1; ftw = w2; end
         macc = {1'b0, macc[31:0]} + {1'b0, cur};
         push(macc[31:20], macc[32]);
         step();
         if (n == 15) chk({name, "_busy_before_wrap"}, 32'(ftw_busy), 32'd1);
         if (n == 16) begin
            chk({name, "_busy_after_wrap"}, 32'(ftw_busy), 32'd0);
            cur = (n2 > 0) ? w2 : w1;
         end
      end
      drain({name, "_drain"});
   endtask

   initial begin
      vecs[0] = '{1'b1, 32'h0000_00FF, 32'h0000_1000, 12'h001};
      vecs[1] = '{1'b0, 32'h0000_00FF, 32'h0000_1000, 12'h000};
      vecs[2] = '{1'b1, 32'h0000_0000, 32'h0000_1000, 12'h000};
      vecs[3] = '{1'b1, 32'hABCD_E080, 32'h0008_0000, 12'h001};
      vecs[4] = '{1'b1, 32'h0000_00FF, 32'h00F0_1000, 12'h010};
      vecs[5] = '{1'b0, 32'h0000_00FF, 32'h00F0_1000, 12'h00F};

      rst = 1'b1;
      enable = 0; phase_clr = 0; ftw_dv = 0; dither_en = 0; lfsr = 0; ftw = 0;
      #1;
      chk("rst_phase", 32'(phase), 32'd0);
      chk("rst_dv", 32'(phase_dv), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      chk("rst_busy", 32'(ftw_busy), 32'd0);

      // Basic accumulation and wrap at sample 256.
      apply_reset();
      write_idle(32'h0100_0000);
      enable = 1'b1;
      chk("lfsr_enable", 32'(lfsr_enable), 32'd1);
      for (int n = 1; n <= 256; n++) begin
         push(12'((n * 16) & 12'hFFF), n == 256);
         step();
         if (n == 1) chk("latency_dv_edge1", 32'(phase_dv), 32'd0);
         if (n == 2) chk("latency_dv_edge2", 32'(phase_dv), 32'd1);
      end
      drain("basic_drain");
      chk("lfsr_enable_off", 32'(lfsr_enable), 32'd0);

      // Dither vectors: single sample each.
      for (int i = 0; i < 6; i++) begin
         apply_reset();
         write_idle(vecs[i].ftw);
         dither_en = vecs[i].den;
         lfsr      = vecs[i].lfsr;
         enable    = 1'b1;
         push(vecs[i].phase, 1'b0);
         step();
         enable = 1'b0;
         step();
         step();
         chk("dither_vec_drain", q.size(), 32'd0);
      end

      // Phase clear while running.
      apply_reset();
      write_idle(32'h0100_0000);
      enable = 1'b1;
      push(12'h010, 0); step();
      push(12'h020, 0); step();
      push(12'h030, 0); step();
      phase_clr = 1'b1;
      push(12'h000, 0); step();
      phase_clr = 1'b0;
      push(12'h010, 0); step();
      drain("clr_drain");

      // Pending update and last-write-wins.
      run_pending("pending", 32'h2000_0000, 3, 32'h0, 0, 20);
      run_pending("lastwin", 32'h2000_0000, 3, 32'h4000_0000, 5, 20);

      // Enable drop while pending applies the shadow immediately; acc holds.
      apply_reset();
      write_idle(32'h1000_0000);
      enable = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         ftw_dv = (n == 3);
         ftw    = 32'h2000_0000;
         push(12'(n * 12'h100), 1'b0);
         step();
      end
      ftw_dv = 1'b0;
      chk("drop_busy_pending", 32'(ftw_busy), 32'd1);
      enable = 1'b0;
      step();
      chk("drop_busy_cleared", 32'(ftw_busy), 32'd0);
      step();
      chk("drop_dv_low", 32'(phase_dv), 32'd0);
      chk("drop_phase_hold", 32'(phase), 32'h500);
      enable = 1'b1;
      push(12'h700, 1'b0);
      step();
      drain("drop_drain");

      // Asynchronous reset in the middle of a pending update.
      apply_reset();
      write_idle(32'h0100_0000);
      enable = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         ftw_dv = (n == 2);
         ftw    = 32'h2000_0000;
         push(12'(n * 16), 1'b0);
         step();
      end
      ftw_dv = 1'b0;
      chk("areset_busy_before", 32'(ftw_busy), 32'd1);
      #2;
      rst = 1'b1;
      q.delete();
      #1;
      chk("areset_phase", 32'(phase), 32'd0);
      chk("areset_dv", 32'(phase_dv), 32'd0);
      chk("areset_wrap", 32'(wrap), 32'd0);
      chk("areset_busy", 32'(ftw_busy), 32'd0);
      enable = 1'b0;
      step();
      rst = 1'b0;
      step();
      // FTW was cleared by reset: output sits at zero and never wraps.
      enable = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         push(12'h000, 1'b0);
         step();
      end
      drain("areset_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
